y86_decode_writeback: RTL
=========================

Name: y86_decode_writeback

Overview:
SEQ decode/write-back stage sitting directly downstream of fetch. It consumes icode/ifun/rA/rB and status from fetch and selects source and destination register IDs. It reads valA/valB combinationally from a 15-entry x 64-bit register file. At the end of the instruction cycle it writes valE/valM, returned from execute/memory, into dstE/dstM on the rising clock edge.

Parameters:
- WORD_W, 64, datapath / register width
- NREGS, 15, architectural registers (IDs 0x0-0xE); ID 0xF = RNONE

Ports:
- clk  in  1  system clock; all writes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- icode  in  4  instruction code from fetch
- ifun  in  4  function code from fetch (used only for cmovXX classification)
- rA  in  4  register A field from fetch
- rB  in  4  register B field from fetch
- instr_valid  in  1  fetch reports a legal instruction
- imem_error  in  1  fetch reports an instruction-memory fault
- cnd  in  1  condition result from execute (cmovXX qualification)
- valE  in  WORD_W  ALU result for dstE
- valM  in  WORD_W  memory read data for dstM
- wb_en  in  1  write-back strobe; one pulse per instruction, asserted in the cycle whose closing edge commits
- srcA  out  4  selected A source ID
- srcB  out  4  selected B source ID
- dstE  out  4  selected E destination ID (cnd-qualified)
- dstM  out  4  selected M destination ID
- valA  out  WORD_W  R[srcA], or 0 if srcA = RNONE
- valB  out  WORD_W  R[srcB], or 0 if srcB = RNONE
- dbg_addr  in  4  debug read address
- dbg_data  out  WORD_W  R[dbg_addr], or 0 for 0xF

Behaviour:
- Reset: rst_n low clears all 15 registers to 0 immediately, without waiting for clk. While rst_n is low, valA, valB and dbg_data read 0. srcA/srcB/dstE/dstM remain combinational from the inputs.
- RSP = 0x4, RNONE = 0xF.
- srcA:
  - rA for rrmovq(2), rmmovq(4), OPq(6), pushq(A)
  - RSP for popq(B), ret(9)
  - otherwise RNONE
- srcB:
  - rB for rmmovq, mrmovq(5), OPq
  - RSP for pushq, popq, call(8), ret
  - otherwise RNONE
- dstE:
  - rB for irmovq(3) and OPq
  - rB for rrmovq/cmovXX only if cnd = 1; otherwise RNONE (ifun = 0 is treated as cnd = 1 regardless of input)
  - RSP for pushq, popq, call, ret
  - otherwise RNONE
- dstM: rA for mrmovq and popq; otherwise RNONE.
- Read path:
  - purely combinational, zero latency
  - a read in the same cycle as a write returns the pre-edge (old) value; no bypass
- Write commit: on the rising clk edge when wb_en & instr_valid & ~imem_error & (icode != halt(0)) & (icode != nop(1)):
  - R[dstE] <= valE if dstE != RNONE
  - R[dstM] <= valM if dstM != RNONE
- Simultaneous writes to the same ID (e.g. popq %rsp): M port wins; the register gets valM.
- wb_en held high across multiple edges: each edge re-commits (idempotent for a stable instruction). Fetch/PC logic must pulse wb_en once.
- Illegal icode (> 0xB) or instr_valid = 0: all IDs = RNONE and no write. imem_error has the same effect.
- Reset asserted mid-cycle with wb_en high: reset dominates; no write occurs and the register file stays 0 until rst_n rises. The first commit can happen only on an edge after deassertion.
- No internal state other than the register array; the stage needs no FSM because SEQ sequencing is owned by the PC-update stage.

Decomposition:
- Shared package y86_pkg:
  - icode constants: IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ
  - register IDs: RRSP, RNONE
  - WORD_W
- One sub-module, y86_regfile: 15x64 array, two async read ports plus the debug port, two write ports with M-over-E priority, and async active-low clear.
- The ID-selection logic stays in y86_decode_writeback.

Test Plan:
- Reset: rst_n = 0 for 2 cycles, then 1; sweep dbg_addr 0..14 -> all dbg_data = 0; dbg_addr = 0xF -> 0.
- irmovq $10,%rax: icode 3, rA F, rB 0, valE 10, wb_en pulse.
  - Before the edge: dstE = 0, valA = valB = 0.
  - After the edge: R[0] = 10; R[3] = 0 (no other register changed).
- addq %rax,%rbx (icode 6, rA 0, rB 3) with R[0] = 10, R[3] = 5 -> valA = 10, valB = 5; valE = 15 commits R[3] = 15 at the edge. During the same cycle valB still reads 5.
- popq %rsp (icode B, rA 4) with R[4] = 0x80, valE = 0x88, valM = 0x1234:
  - srcA = srcB = 4, dstE = dstM = 4
  - after the edge R[4] = 0x1234 (M wins)
- cmovle (icode 2, ifun 1, rA 0, rB 2) with cnd = 0 -> dstE = F and R[2] unchanged. Repeat with cnd = 1 -> R[2] = R[0].
- Faults and reset:
  - irmovq with imem_error = 1 or instr_valid = 0 -> no write.
  - Drop rst_n mid-cycle with wb_en = 1 -> all registers read 0 immediately, and no commit at the following edge.

Source files
------------

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 constants for the decode/write-back slice
package y86_pkg;

  localparam int WORD_W = 64;
  localparam int NREGS  = 15;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - 15x64 register file, async reads, M-over-E write priority
module y86_regfile
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        addr_a,
  input  logic [3:0]        addr_b,
  input  logic [3:0]        addr_dbg,
  output logic [WORD_W-1:0] data_a,
  output logic [WORD_W-1:0] data_b,
  output logic [WORD_W-1:0] data_dbg,
  input  logic              we_e,
  input  logic [3:0]        addr_e,
  input  logic [WORD_W-1:0] wdata_e,
  input  logic              we_m,
  input  logic [3:0]        addr_m,
  input  logic [WORD_W-1:0] wdata_m
);

  logic [WORD_W-1:0] regs [NREGS];

  // The M write is issued after the E write so it wins on a shared ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we_e && addr_e != RNONE) regs[addr_e] <= wdata_e;
      if (we_m && addr_m != RNONE) regs[addr_m] <= wdata_m;
    end
  end

  assign data_a   = (!rst_n || addr_a   == RNONE) ? '0 : regs[addr_a];
  assign data_b   = (!rst_n || addr_b   == RNONE) ? '0 : regs[addr_b];
  assign data_dbg = (!rst_n || addr_dbg == RNONE) ? '0 : regs[addr_dbg];

endmodule

// File: rtl/y86_decode_writeback.sv
// rtl/y86_decode_writeback.sv - SEQ decode/write-back: register ID selection and commit
module y86_decode_writeback
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              instr_valid,
  input  logic              imem_error,
  input  logic              cnd,
  input  logic [WORD_W-1:0] valE,
  input  logic [WORD_W-1:0] valM,
  input  logic              wb_en,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [WORD_W-1:0] valA,
  output logic [WORD_W-1:0] valB,
  input  logic [3:0]        dbg_addr,
  output logic [WORD_W-1:0] dbg_data
);

  logic legal;
  logic commit;

  assign legal  = instr_valid && !imem_error && (icode <= IPOPQ);
  assign commit = wb_en && legal && (icode != IHALT) && (icode != INOP);

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    if (legal) begin
      case (icode)
        IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: srcA = rA;
        IPOPQ, IRET:                    srcA = RRSP;
        default:                        srcA = RNONE;
      endcase
      case (icode)
        IRMMOVQ, IMRMOVQ, IOPQ:         srcB = rB;
        IPUSHQ, IPOPQ, ICALL, IRET:     srcB = RRSP;
        default:                        srcB = RNONE;
      endcase
      // ifun 0 is the unconditional rrmovq, so it ignores cnd.
      case (icode)
        IIRMOVQ, IOPQ:                  dstE = rB;
        IRRMOVQ:                        dstE = (cnd || ifun == 4'h0) ? rB : RNONE;
        IPUSHQ, IPOPQ, ICALL, IRET:     dstE = RRSP;
        default:                        dstE = RNONE;
      endcase
      case (icode)
        IMRMOVQ, IPOPQ:                 dstM = rA;
        default:                        dstM = RNONE;
      endcase
    end
  end

  y86_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr_a   (srcA),
    .addr_b   (srcB),
    .addr_dbg (dbg_addr),
    .data_a   (valA),
    .data_b   (valB),
    .data_dbg (dbg_data),
    .we_e     (commit),
    .addr_e   (dstE),
    .wdata_e  (valE),
    .we_m     (commit),
    .addr_m   (dstM),
    .wdata_m  (valM)
  );

endmodule
